// File: rtl/cp0_ctrl.sv
// Coprocessor-0 exception/interrupt controller beside the M stage: trap decision, SR/Cause/EPC/PRId, mfc0/mtc0, eret.
// Optional Count/Compare timer enabled by defining CP0_TIMER_EN.
module cp0_ctrl #(
  parameter logic [31:0] PRID = 32'h2023_0707
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wData,
  output logic [31:0] rData,
  input  logic [31:0] vPC,
  input  logic        isBD,
  input  logic [4:0]  excCode,
  input  logic [5:0]  hwInt,
  input  logic        eret,
  output logic        req,
  output logic [31:0] epcOut
);

  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic        bd_r;
  logic [5:0]  ip_r;
  logic [4:0]  exc_code_r;
  logic [31:0] epc_r;

  logic [5:0]  ip_in_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        wr_s;

`ifdef CP0_TIMER_EN
  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        tpend_r;

  // Free-running counter, compare register and sticky match flag
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r   <= 32'h0;
      compare_r <= 32'h0;
      tpend_r   <= 1'b0;
    end else begin
      if (wr_s && (addr == 5'd9)) begin
        count_r <= wData;
      end else begin
        count_r <= count_r + 32'd1;
      end
      if (wr_s && (addr == 5'd11)) begin
        compare_r <= wData;
      end else begin
        compare_r <= compare_r;
      end
      // An mtc0 to Compare acknowledges the timer even if it matches this cycle
      if (wr_s && (addr == 5'd11)) begin
        tpend_r <= 1'b0;
      end else if ((count_r == compare_r) && (compare_r != 32'h0)) begin
        tpend_r <= 1'b1;
      end else begin
        tpend_r <= tpend_r;
      end
    end
  end

  assign ip_in_s = {hwInt[5] | tpend_r, hwInt[4:0]};
`else
  assign ip_in_s = hwInt;
`endif

  assign int_req_s = ie_r & ~exl_r & (|(ip_in_s & im_r));
  assign exc_req_s = ~exl_r & (excCode != 5'd0);
  assign req_s     = int_req_s | exc_req_s;
  // A trap in the same cycle discards any mtc0
  assign wr_s      = we & ~req_s;

  assign req    = req_s;
  assign epcOut = (we && (addr == 5'd14)) ? wData : epc_r;

  // Trap capture, eret and mtc0 updates of SR/Cause/EPC
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      im_r       <= 6'h0;
      exl_r      <= 1'b0;
      ie_r       <= 1'b0;
      bd_r       <= 1'b0;
      ip_r       <= 6'h0;
      exc_code_r <= 5'h0;
      epc_r      <= 32'h0;
    end else begin
      ip_r <= ip_in_s;
      if (req_s) begin
        exl_r      <= 1'b1;
        bd_r       <= isBD;
        exc_code_r <= int_req_s ? 5'd0 : excCode;
        epc_r      <= isBD ? (vPC - 32'd4) : vPC;
      end else begin
        if (wr_s && (addr == 5'd12)) begin
          im_r <= wData[15:10];
          ie_r <= wData[0];
        end else begin
          im_r <= im_r;
          ie_r <= ie_r;
        end
        if (eret) begin
          exl_r <= 1'b0;
        end else if (wr_s && (addr == 5'd12)) begin
          exl_r <= wData[1];
        end else begin
          exl_r <= exl_r;
        end
        if (wr_s && (addr == 5'd14)) begin
          epc_r <= wData;
        end else begin
          epc_r <= epc_r;
        end
      end
    end
  end

  // mfc0 read mux, pre-edge values only
  always_comb begin
    rData = 32'h0;
    case (addr)
      5'd12:   rData = {16'h0, im_r, 8'h0, exl_r, ie_r};
      5'd13:   rData = {bd_r, 15'h0, ip_r, 3'h0, exc_code_r, 2'h0};
      5'd14:   rData = epc_r;
      5'd15:   rData = PRID;
`ifdef CP0_TIMER_EN
      5'd9:    rData = count_r;
      5'd11:   rData = compare_r;
`endif
      default: rData = 32'h0;
    endcase
  end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 exception/interrupt controller for the pipelined MIPS core. It sits beside the M stage and receives the ALU overflow and other exception codes from the pipeline, plus six external interrupt lines. It decides whether the in-flight instruction traps and records SR/Cause/EPC state for the handler. It also serves mfc0/mtc0 accesses and eret.

## Interface
- PRID, 32'h2023_0707: read-only value of PRId (reg 15).
- clk  in  1  single clock; all state updates on posedge.
- resetN  in  1  reset, asynchronous and active-low.
- we  in  1  mtc0 write strobe (M stage).
- addr  in  5  CP0 register number for mtc0/mfc0.
- wData  in  32  mtc0 write data.
- rData  out  32  mfc0 read data, combinational from addr.
- vPC  in  32  PC of the M-stage instruction.
- isBD  in  1  M-stage instruction is in a branch delay slot.
- excCode  in  5  pending exception code: 0 none, 4 AdEL, 5 AdES, 8 Syscall, 10 RI, 12 Ov (ALU overflow).
- hwInt  in  6  external interrupt lines, level-sensitive.
- eret  in  1  eret in M stage.
- req  out  1  trap now; pipeline flushes and redirects to the handler.
- epcOut  out  32  return address for eret.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0] writable; all other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; software writes ignored.
  - EPC (14): 32 bits, fully writable.
  - PRId (15): constant PRID.
  - Any other addr reads 0; writes to it have no effect.
- IP[15:10] is loaded with the effective interrupt vector every cycle, regardless of EXL.
- intReq = IE & ~EXL & |(IP_in & IM). IP_in is hwInt, OR'd per Configuration.
- excReq = ~EXL & (excCode != 0).
- req = intReq | excReq.
- On a clock edge with req=1:
  - EXL <= 1.
  - BD <= isBD.
  - ExcCode <= intReq ? 0 : excCode. Interrupt takes priority over a synchronous exception.
  - EPC <= isBD ? vPC-4 : vPC, computed modulo 2^32.
  - An mtc0 in the same cycle is discarded.
- eret with req=0: EXL <= 0 at the edge.
- eret with req=1: req wins and EXL stays 1.
- mtc0 with req=0: the addressed register updates at the edge.
- epcOut = (we && addr==14) ? wData : EPC. This forwards a same-cycle mtc0 EPC.
- rData shows the pre-edge value. There is no read-during-write bypass except epcOut.

## Timing
- req, rData and epcOut are combinational, with zero-cycle latency from their inputs.
- State changes become visible the cycle after the edge.
- Async reset (resetN=0) clears SR, Cause, EPC, Count and Compare to 0 immediately, mid-instruction included.
- After reset, IE=0, so interrupts are masked. Exceptions are still accepted, since EXL=0.
- Nested trap is suppressed while EXL=1: req=0 even if excCode!=0 or interrupts are pending.
- hwInt is sampled every cycle. A pulse shorter than one cycle that misses the edge is lost; that is acceptable.

## Configuration
- CP0_TIMER_EN defined: adds Count (reg 9) and Compare (reg 11).
  - Count increments every cycle and wraps 32'hFFFF_FFFF -> 0. mtc0 to Count loads wData instead of incrementing that cycle.
  - Compare is writable.
  - A timer-pending flag sets when Count==Compare and Compare!=0. It clears on any mtc0 to Compare, and the clear wins over a same-cycle match.
  - The flag is OR'd into IP_in[5] (Cause bit 15).
- CP0_TIMER_EN undefined: regs 9 and 11 read 0 and ignore writes, and IP_in = hwInt exactly.

## Test plan
- Reset, then excCode=12, vPC=32'h3008, isBD=0 -> req=1. After the edge, EPC=32'h3008, ExcCode=12, EXL=1. A second Ov next cycle gives req=0.
- Exception in delay slot: excCode=4, vPC=32'h3010, isBD=1 -> EPC=32'h300C, BD=1.
- mtc0 SR=32'h0000_0401, then hwInt=6'b000001 -> req=1, ExcCode=0. With hwInt=6'b000010 the interrupt is masked and req=0.
- Simultaneous interrupt and excCode=10 with SR enabled -> ExcCode=0. A same-cycle mtc0 to EPC is ignored.
- eret with EXL=1 -> EXL=0 next cycle; epcOut equals EPC. Same-cycle mtc0 EPC=32'h3100 with eret -> epcOut=32'h3100.
- CP0_TIMER_EN: Compare=5, SR=32'h0000_8001, Count from 0 -> req asserts when Count reaches 5. Writing Compare clears the pending flag.
